// File: rtl/rv32m_ext_unit_if.sv
// rv32m_ext_unit_if
// Handshake bundle between the execute stage (initiator) and the external
// RV32M multiply/divide unit.
//   i_en    : start pulse, operands valid in this cycle
//   i_rs1   : operand A (multiplicand / dividend)
//   i_rs2   : operand B (multiplier / divisor)
//   i_f3    : RV32M funct3
//   o_res   : result, valid with o_ack and held until the next completion
//   o_ack   : one-cycle completion strobe
//   o_busy  : unit is computing or completing
`ifndef XLEN
`define XLEN 32
`endif

interface rv32m_ext_unit_if;
  logic              i_en;
  logic [`XLEN-1:0]  i_rs1;
  logic [`XLEN-1:0]  i_rs2;
  logic [2:0]        i_f3;
  logic [`XLEN-1:0]  o_res;
  logic              o_ack;
  logic              o_busy;

  modport master (
    output i_en, i_rs1, i_rs2, i_f3,
    input  o_res, o_ack, o_busy
  );

  modport slave (
    input  i_en, i_rs1, i_rs2, i_f3,
    output o_res, o_ack, o_busy
  );
endinterface

// File: rtl/rv32m_ext_unit.sv
// rv32m_ext_unit
// Iterative RV32M multiply/divide unit. Operands are latched on a start pulse
// in IDLE, converted to magnitudes, and processed one bit per cycle for 32
// cycles (shift-add multiply or restoring divide). Sign correction and result
// selection are registered on the final step, so o_res has no path from the
// inputs. Divide-by-zero and signed overflow complete in one cycle.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous reset, active-high
//   bus    : rv32m_ext_unit_if slave (i_en/i_rs1/i_rs2/i_f3 in,
//            o_res/o_ack/o_busy out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_en; latches operands and funct3
// CALC  | one multiply/divide iteration per cycle, cnt_q = 0..31
// DONE  | o_ack high for one cycle, o_res freshly updated

module rv32m_ext_unit (
  input  logic           i_clk,
  input  logic           i_rst,
  rv32m_ext_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2:0]         f3_q, f3_d;
  logic [63:0]        acc_q, acc_d;
  logic [`XLEN-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [`XLEN-1:0]   res_q, res_d;

  // operand conditioning at latch time
  logic               a_sgn, b_sgn;
  logic [`XLEN-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;

  // one iteration of either algorithm
  logic [32:0]        mul_sum;
  logic [63:0]        mul_next;
  logic [32:0]        div_rem;
  logic [32:0]        div_diff;
  logic [63:0]        div_next;
  logic [63:0]        step_acc;

  // final formatting
  logic [63:0]        prod_fix;
  logic [`XLEN-1:0]   quo, rem;
  logic [`XLEN-1:0]   fmt_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.i_f3)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = bus.i_rs1[31];
        b_sgn = bus.i_rs2[31];
      end
      3'b010:  a_sgn = bus.i_rs1[31];
      default: ;
    endcase
  end

  assign a_mag    = a_sgn ? -bus.i_rs1 : bus.i_rs1;
  assign b_mag    = b_sgn ? -bus.i_rs2 : bus.i_rs2;
  assign div_zero = bus.i_f3[2] && (bus.i_rs2 == '0);
  // only DIV (100) and REM (110) are signed divides
  assign div_ovf  = bus.i_f3[2] && !bus.i_f3[0] &&
                    (bus.i_rs1 == 32'h8000_0000) && (bus.i_rs2 == 32'hFFFF_FFFF);

  // multiply: acc = {partial product high, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // divide: acc = {remainder, quotient}; the shifted remainder needs 33 bits
  // and the difference's top bit is its sign
  assign div_rem  = acc_q[63:31];
  assign div_diff = div_rem - {1'b0, b_q};
  assign div_next = div_diff[32] ? {div_rem[31:0], acc_q[30:0], 1'b0}
                                 : {div_diff[31:0], acc_q[30:0], 1'b1};

  assign step_acc = f3_q[2] ? div_next : mul_next;

  assign prod_fix = neg_q ? -step_acc : step_acc;
  assign quo      = step_acc[31:0];
  assign rem      = step_acc[63:32];

  always_comb begin
    fmt_res = '0;
    case (f3_q)
      3'b000:                 fmt_res = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fmt_res = prod_fix[63:32];
      3'b100:                 fmt_res = neg_q ? -quo : quo;
      3'b101:                 fmt_res = quo;
      3'b110:                 fmt_res = rneg_q ? -rem : rem;
      default:                fmt_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.i_en) begin
          f3_d   = bus.i_f3;
          neg_d  = a_sgn ^ b_sgn;
          rneg_d = a_sgn;
          cnt_d  = 5'd0;
          // multiply: b_q holds multiplicand, acc low holds multiplier
          // divide:   b_q holds divisor,      acc low holds dividend
          b_d    = bus.i_f3[2] ? b_mag : a_mag;
          acc_d  = {32'd0, (bus.i_f3[2] ? a_mag : b_mag)};
          if (div_zero) begin
            res_d   = bus.i_f3[1] ? bus.i_rs1 : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = bus.i_f3[1] ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          res_d   = fmt_res;
          cnt_d   = 5'd0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_res  = res_q;
  assign bus.o_ack  = (state_q == DONE);
  assign bus.o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_rv32m_ext_unit.sv
// tb_rv32m_ext_unit
// Bench for rv32m_ext_unit: directed cases with literal expectations, protocol
// and reset scenarios, then randomized operations. A behavioural model built on
// 64-bit integer arithmetic predicts ack/busy/result every cycle.
module tb_rv32m_ext_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32m_ext_unit_if bus();

  rv32m_ext_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // model: one accepted operation at a time, known latency
  int          cyc = 0;
  bit          model_ok = 0;
  bit          pend = 0;
  int          start_cyc = 0;
  int          ack_cyc = 0;
  logic [31:0] exp_val = '0;
  logic [31:0] last_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1;
      pend     = 0;
      last_res = '0;
    end else if (model_ok && bus.i_en && !(pend && cyc <= ack_cyc)) begin
      pend      = 1;
      start_cyc = cyc;
      ack_cyc   = cyc + (is_special(bus.i_f3, bus.i_rs1, bus.i_rs2) ? 1 : 33);
      exp_val   = ref_model(bus.i_f3, bus.i_rs1, bus.i_rs2);
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic e_ack, e_busy;
      e_ack  = pend && (cyc == ack_cyc);
      e_busy = pend && (cyc > start_cyc) && (cyc <= ack_cyc);
      if (e_ack) last_res = exp_val;
      check("ack",  {31'd0, bus.o_ack},  {31'd0, e_ack});
      check("busy", {31'd0, bus.o_busy}, {31'd0, e_busy});
      check("res",  bus.o_res, last_res);
    end
  end

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit junk);
    int k;
    bit got;
    bus.i_en = 1'b1; bus.i_f3 = f3; bus.i_rs1 = a; bus.i_rs2 = b;
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    k = 1; got = 0;
    while (k <= 40 && !got) begin
      if (junk && $urandom_range(0, 5) == 0) begin
        bus.i_en = 1'b1; bus.i_f3 = 3'($urandom); bus.i_rs1 = $urandom; bus.i_rs2 = $urandom;
      end else begin
        bus.i_en = 1'b0;
      end
      @(negedge clk);
      if (bus.o_ack) got = 1;
      if (got) check({nm, "_res"}, bus.o_res, exp_res);
      @(posedge clk); #1;
      if (!got) k++;
    end
    bus.i_en = 1'b0;
    check({nm, "_lat"}, 32'(k), 32'(exp_lat));
  endtask

  initial begin
    int nack, a1, a2;
    logic [31:0] r1, r2;
    rst = 1'b1;
    bus.i_en = 1'b0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_f3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_ack",  {31'd0, bus.o_ack},  32'd0);
    check("rst_res",  bus.o_res, 32'd0);
    @(posedge clk); #1;

    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("divu",   3'd5, 32'hFFFF_FFFE, 32'd3,         32'h5555_5554, 33, 0);
    run_op("remu",   3'd7, 32'hFFFF_FFFE, 32'd3,         32'd2,         33, 0);
    run_op("div0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("remu0",  3'd7, 32'd5,         32'd0,         32'd5,         1,  0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0);

    // ignored pulses in cycles 5 and 33, accepted pulse in cycle 34
    nack = 0; a1 = -1; a2 = -1; r1 = '0; r2 = '0;
    for (int c = 0; c <= 70; c++) begin
      bus.i_en = (c == 0 || c == 5 || c == 33 || c == 34);
      if (c == 0)       begin bus.i_f3 = 3'd0; bus.i_rs1 = 32'd6;   bus.i_rs2 = 32'd7; end
      else if (c == 34) begin bus.i_f3 = 3'd5; bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7; end
      else              begin bus.i_f3 = 3'd3; bus.i_rs1 = '1;      bus.i_rs2 = '1;    end
      @(negedge clk);
      if (bus.o_ack) begin
        if (nack == 0) begin a1 = c; r1 = bus.o_res; end
        else if (nack == 1) begin a2 = c; r2 = bus.o_res; end
        nack++;
      end
      @(posedge clk); #1;
    end
    bus.i_en = 1'b0;
    check("proto_nack", 32'(nack), 32'd2);
    check("proto_ack1", 32'(a1), 32'd33);
    check("proto_res1", r1, 32'd42);
    check("proto_ack2", 32'(a2), 32'd67);
    check("proto_res2", r2, 32'd14);

    // reset in cycle 10 of a DIVU
    nack = 0;
    for (int c = 0; c <= 56; c++) begin
      bus.i_en = (c == 0);
      bus.i_f3 = 3'd5; bus.i_rs1 = 32'hFFFF_FFFE; bus.i_rs2 = 32'd3;
      rst = (c == 10);
      @(negedge clk);
      if (bus.o_ack) nack++;
      if (c == 11) begin
        check("rstmid_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rstmid_res",  bus.o_res, 32'd0);
      end
      @(posedge clk); #1;
    end
    bus.i_en = 1'b0;
    check("rstmid_noack", 32'(nack), 32'd0);
    run_op("mul34", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

    // randomized operations, some with stray pulses while busy
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom);
      a  = rand_opnd();
      b  = rand_opnd();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op("rnd", f3, a, b, ref_model(f3, a, b), is_special(f3, a, b) ? 1 : 33,
             bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32m_ext_unit.md
# rv32m_ext_unit

Multi-cycle RV32M multiply/divide unit that sits outside the datapath and serves the execute stage's external-M handshake. It samples operands and funct3 on a one-cycle enable pulse and computes iteratively. It returns the 32-bit result with a one-cycle acknowledge, which releases the execute-stage stall. All eight RV32M operations are supported, including the ISA-defined divide-by-zero and signed-overflow results.

## Interface

Parameters: none; width is `XLEN (32).

- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  start pulse; operands valid in this cycle
- i_rs1  in  `XLEN  operand A (multiplicand / dividend)
- i_rs2  in  `XLEN  operand B (multiplier / divisor)
- i_f3  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- o_res  out  `XLEN  result; valid when o_ack=1, held until next completion
- o_ack  out  1  one-cycle completion strobe
- o_busy  out  1  high in CALC and DONE

## Operation

- **States.**
  - IDLE: o_busy=0. On i_en=1, latch i_rs1, i_rs2 and i_f3. If the operation is a special case, go to DONE; otherwise go to CALC with step counter = 0.
  - CALC: performs one iteration per cycle. After the 32nd iteration (counter = 31), go to DONE.
  - DONE: o_ack=1 and o_res is updated in this cycle. Next state is IDLE.
- **Ignored enables.** i_en in CALC or DONE is ignored; there is no queueing.
- **Signedness.** rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM. Signed operands are converted to magnitudes at latch time, and the result sign is recorded.
- **Multiply.**
  - Shift-add over a 64-bit accumulator: add the multiplicand when the multiplier LSB is 1, then shift right.
  - Negate the 64-bit product if the operand signs differ.
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
- **Divide.**
  - Restoring division: shift the {remainder, quotient} pair left by 1. If remainder ≥ divisor, subtract the divisor and set quotient bit 0.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- **Special cases (IDLE → DONE directly).**
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- **Result formatting.** The final sign correction and result selection happen at the CALC → DONE transition, so o_res is registered, with no combinational path from the inputs.
- **Reset.** i_rst=1 in any state forces IDLE, o_ack=0, o_busy=0, o_res=0, and clears the step counter. An in-flight operation is abandoned and never acknowledged.

## Timing

- Cycle 0 is the cycle in which i_en=1 is sampled in IDLE.
- Normal operation: CALC occupies cycles 1–32, and o_ack=1 in cycle 33. Latency is 33 cycles.
- Special case: o_ack=1 in cycle 1.
- o_ack is high for exactly one cycle per accepted pulse. o_res keeps its value after o_ack falls.
- Back-to-back operations: the unit returns to IDLE in the cycle after DONE, so a new pulse can be accepted in cycle 34 (or in cycle 2 after a special case).
- An i_en in the same cycle as i_rst is discarded.
- The initiator treats o_ack as i_ack: its stall falls in the ack cycle and its enable logic clears on the same edge. The unit must therefore never assert o_ack without an accepted pulse.

## Test plan

- **MUL.** rs1=7, rs2=0xFFFFFFFD, f3=000 → o_res=0xFFFFFFEB. o_ack is high in cycle 33 only, and o_busy is high in cycles 1–33.
- **High-half multiplies.**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- **Divides.**
  - DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE/3 → 0x55555554; REMU → 2.
- **Special cases.**
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - In all four, o_ack is in cycle 1.
- **Protocol.** Extra i_en pulses in cycles 5 and 33 are ignored: a single ack in cycle 33 with the original result. A new pulse in cycle 34 is accepted and acked in cycle 67.
- **Reset mid-operation.** i_rst in cycle 10 of a DIVU → o_busy=0, o_res=0 next cycle, and no ack ever appears. A subsequent MUL 3×4 returns 12 with normal latency.
